unidad_logica_param: RTL and testbench
======================================

Name: unidad_logica_param

Overview:
Parametrised successor to the single-bit NOT gate. It is a WIDTH-bit registered logic unit with eight selectable gate functions.
- The default function is NOT, so reset behaviour matches the plain inverter.
- The operation is stepped by a debounced push-button (Nexys A7 BTN) or loaded directly.
- Output is registered with a valid flag, so it can feed LEDs or downstream logic.

Parameters:
WIDTH, 8, operand/result width in bits (1..32)
DEB_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); minimum 1
RESET_OP, 0, operation code loaded on reset

Ports:
clk  input  1  system clock (100 MHz on board)
rst  input  1  synchronous, active-high reset
a  input  WIDTH  operand A
b  input  WIDTH  operand B (ignored by NOT and BUF)
in_valid  input  1  operands valid this cycle
btn_next  input  1  raw asynchronous push-button; each accepted press advances the operation
op_load  input  1  load op_in into the operation register
op_in  input  3  operation code for op_load
out  output  WIDTH  registered result
out_valid  output  1  out updated this cycle
op_cur  output  3  current operation code (for LED/7-seg display)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; all state is cleared only on a rising clk edge with rst=1.
- Reset values: out=0, out_valid=0, op_cur=RESET_OP, synchroniser flops=0, debounced level=0, debounce counter=0.
- Op codes:
  - 0 NOT a
  - 1 AND
  - 2 OR
  - 3 XOR
  - 4 NAND
  - 5 NOR
  - 6 XNOR
  - 7 BUF a
- All operations are bitwise over WIDTH bits.
- Button path:
  - Synchroniser: 2-flop, s1 then s2.
  - Debounce: 
    - Counter increments while s2 != deb_level.
    - Counter clears to 0 when s2 == deb_level.
    - When the counter reaches DEB_CYCLES-1 with s2 still != deb_level, deb_level <= s2 and the counter clears.
  - Press pulse: 1-cycle pulse `press` on the 0->1 transition of deb_level. Release generates no pulse.
  - Latency: a clean btn_next rise first sampled at edge k sets s1 at k and s2 at k+1; deb_level rises at edge k+DEB_CYCLES+1; op_cur changes at edge k+DEB_CYCLES+2.
  - Glitch rejection: any bounce shorter than DEB_CYCLES cycles produces no press.
- Operation register:
  - op_load=1: op_cur <= op_in.
  - else press=1: op_cur <= op_cur+1, with wrap 7->0.
  - op_load has priority; a simultaneous press is discarded, not deferred.
- Datapath, latency 1:
  - On an edge with in_valid=1: out <= f(op_cur, a, b), using op_cur's value before that edge. An op change on the same edge affects only later samples.
  - out_valid <= in_valid every cycle.
  - When in_valid=0, out holds its previous value.
- Reset mid-operation:
  - Debounce progress is discarded.
  - A button held through reset is seen as a new press after it debounces again; deb_level restarts at 0.
- No combinational path from any input to any output.

Decomposition:
- Package puertas_pkg: op-code localparams (OP_NOT..OP_BUF), op width 3, and a function aplicar_op(op, a, b) returning the WIDTH-bit result.
- Sub-module antirrebote (params DEB_CYCLES): btn_raw in; press pulse and level out. It contains the synchroniser, debounce counter (width $clog2(DEB_CYCLES+1)) and edge detect. Reusable for other board buttons.

Test Plan:
All scenarios use WIDTH=8, DEB_CYCLES=4.
1. Reset, then in_valid=1, a=8'hA5 -> next cycle out=8'h5A, out_valid=1, op_cur=0.
2. op_load=1, op_in=3; then a=8'hF0, b=8'h3C, in_valid=1 -> op_cur=3, out=8'hCC one cycle later. in_valid=0 next cycle -> out stays 8'hCC, out_valid=0.
3. btn_next high clean from edge k -> op_cur 0->1 exactly at edge k+6. Hold the button 20 cycles -> only one increment. Release -> no change.
4. btn_next toggling every 2 cycles for 20 cycles, then low -> op_cur unchanged.
5. op_cur=7, one accepted press -> op_cur=0 (wrap). Press pulse coincident with op_load=1, op_in=5 -> op_cur=5.
6. rst asserted for 1 cycle while the debounce counter is mid-count with out=8'hFF -> after the edge out=0, out_valid=0, op_cur=0. A still-held button yields a press DEB_CYCLES+2 cycles after rst deasserts.

Source files
------------

// File: rtl/puertas_pkg.sv
// Shared op-code definitions and the bitwise gate function for the logic unit.
package puertas_pkg;

  localparam int OP_W  = 3;
  localparam int MAX_W = 32;

  localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
  localparam logic [OP_W-1:0] OP_AND  = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_BUF  = 3'd7;

  // Works at the maximum width; callers zero-extend operands and truncate the result.
  function automatic logic [MAX_W-1:0] aplicar_op(input logic [OP_W-1:0]  op,
                                                  input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    case (op)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Push-button conditioner: 2-flop synchroniser, level debouncer and rising-edge press pulse.
module antirrebote #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press,
  output logic level
);

  localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign press = level_q & ~prev_q;
  assign level = level_q;

endmodule

// File: rtl/unidad_logica_param.sv
// WIDTH-bit registered logic unit with eight gate functions, stepped by a debounced button.
module unidad_logica_param
  import puertas_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 1000000,
  parameter int RESET_OP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             btn_next,
  input  logic             op_load,
  input  logic [OP_W-1:0]  op_in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [OP_W-1:0]  op_cur
);

  logic             press;
  logic             btn_level_unused;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q;

  antirrebote #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_antirrebote (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_next),
    .press  (press),
    .level  (btn_level_unused)
  );

  // Load wins over a coincident press; the press is dropped, not queued.
  always_comb begin
    op_d = op_q;
    if (op_load) begin
      op_d = op_in;
    end else if (press) begin
      op_d = op_q + OP_W'(1);
    end
  end

  always_comb begin
    out_d = out_q;
    if (in_valid) begin
      out_d = WIDTH'(aplicar_op(op_q, MAX_W'(a), MAX_W'(b)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_W'(RESET_OP);
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      op_q    <= op_d;
      out_q   <= out_d;
      valid_q <= in_valid;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign op_cur    = op_q;

endmodule

// File: tb/tb_unidad_logica_param.sv
// Scoreboard bench for unidad_logica_param (WIDTH=8, DEB_CYCLES=4).
module tb_unidad_logica_param;

  localparam int W   = 8;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, btn_next, op_load;
  logic [W-1:0] a, b, out;
  logic [2:0]   op_in, op_cur;
  logic         out_valid;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb_q[$];

  // Reference model state
  logic [2:0]   m_op;
  logic [W-1:0] m_out;
  bit           m_valid, m_pend, m_level, m_s1, m_s2;
  bit           hist[$];
  bit           mon_en = 1'b0;

  always #5 clk = ~clk;

  unidad_logica_param #(
    .WIDTH     (W),
    .DEB_CYCLES(DEB),
    .RESET_OP  (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .btn_next (btn_next),
    .op_load  (op_load),
    .op_in    (op_in),
    .out      (out),
    .out_valid(out_valid),
    .op_cur   (op_cur)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_f(input logic [2:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    case (op)
      3'd0:    return ~x;
      3'd1:    return x & y;
      3'd2:    return x | y;
      3'd3:    return x ^ y;
      3'd4:    return ~(x & y);
      3'd5:    return ~(x | y);
      3'd6:    return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  // One clock: drive at negedge, queue the expected result, advance the model at posedge.
  task automatic cyc(input bit r, input logic [W-1:0] xa, input logic [W-1:0] xb,
                     input bit iv, input bit bt, input bit ld, input logic [2:0] oi);
    bit win;
    @(negedge clk);
    rst = r; a = xa; b = xb; in_valid = iv; btn_next = bt; op_load = ld; op_in = oi;
    if (iv && !r) sb_q.push_back(ref_f(m_op, xa, xb));
    @(posedge clk);
    if (r) begin
      m_op = 3'd0; m_out = '0; m_valid = 1'b0; m_pend = 1'b0;
      m_level = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
      hist.delete();
    end else begin
      if (iv) m_out = ref_f(m_op, xa, xb);
      m_valid = iv;
      if (ld) m_op = oi;
      else if (m_pend) m_op = m_op + 3'd1;
      // Accept a new level once the synchronised button has disagreed for DEB straight samples.
      hist.push_back(m_s2);
      if (hist.size() > DEB) void'(hist.pop_front());
      m_s2 = m_s1;
      m_s1 = bt;
      win = (hist.size() == DEB);
      foreach (hist[i]) if (hist[i] == m_level) win = 1'b0;
      m_pend = 1'b0;
      if (win) begin
        m_level = ~m_level;
        m_pend  = m_level;
      end
    end
  endtask

  task automatic idle(input bit bt, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, bt, 1'b0, 3'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a valid result.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("out_valid", out_valid, m_valid);
        chk("op_cur", op_cur, m_op);
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got out=%0h with no expected entry", out);
          end else begin
            e = sb_q.pop_front();
            chk("out_sb", out, e);
          end
        end else begin
          chk("out_hold", out, m_out);
        end
      end
    end
  end

  initial begin
    int run;
    bit bt;
    rst = 1'b1; a = '0; b = '0; in_valid = 1'b0; btn_next = 1'b0; op_load = 1'b0; op_in = '0;
    cyc(1'b1, '0, '0, 1'b1, 1'b0, 1'b0, 3'd0);
    cyc(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 3'd0);
    mon_en = 1'b1;
    #1;
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_op", op_cur, 0);

    // NOT after reset
    cyc(1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    chk("not_out", out, 8'h5A);
    chk("not_valid", out_valid, 1);
    chk("not_op", op_cur, 0);

    // Load XOR, then hold
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 3'd3);
    cyc(1'b0, 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    chk("xor_op", op_cur, 3);
    chk("xor_out", out, 8'hCC);
    cyc(1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 3'd0);
    #1;
    chk("hold_out", out, 8'hCC);
    chk("hold_valid", out_valid, 0);

    // Clean press: op_cur changes exactly at edge k+6
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 3'd0);
    for (int i = 0; i <= 6; i++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 3'd0);
      #1;
      chk("press_lat", op_cur, (i == 6) ? 1 : 0);
    end
    idle(1'b1, 20);
    #1 chk("held_once", op_cur, 1);
    idle(1'b0, 10);
    #1 chk("release", op_cur, 1);

    // Bounce shorter than DEB is rejected
    for (int i = 0; i < 20; i++) cyc(1'b0, '0, '0, 1'b0, ((i / 2) % 2) == 0, 1'b0, 3'd0);
    idle(1'b0, 10);
    #1 chk("bounce", op_cur, 1);

    // Wrap 7 -> 0, then press discarded by a coincident load
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 3'd7);
    idle(1'b1, 7);
    #1 chk("wrap", op_cur, 0);
    idle(1'b0, 8);
    idle(1'b1, 6);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 3'd5);
    #1 chk("load_prio", op_cur, 5);
    idle(1'b0, 8);
    #1 chk("load_no_defer", op_cur, 5);

    // Reset mid-debounce
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 3'd0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    #1 chk("ff_out", out, 8'hFF);
    idle(1'b1, 3);
    cyc(1'b1, '0, '0, 1'b0, 1'b1, 1'b0, 3'd0);
    #1;
    chk("mid_rst_out", out, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_op", op_cur, 0);
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 3'd0);
      #1 chk("post_rst_press", op_cur, (i == 7) ? 1 : 0);
    end
    idle(1'b0, 8);

    // Randomised traffic
    run = 0;
    bt = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (run == 0) begin
        bt  = ~bt;
        run = $urandom_range(1, 9);
      end
      run--;
      cyc(($urandom_range(0, 79) == 0), W'($urandom), W'($urandom), $urandom_range(0, 1) == 1,
          bt, ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)));
    end
    idle(1'b0, 12);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
